// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : loader_pkg                                                       |
// | Purpose : Shared definitions for the instruction-memory boot loader:       |
// |           FSM state encoding, default start-of-frame byte, frame field     |
// |           widths and the frame length limit helper.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package loader_pkg;

  // Default start-of-frame marker
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Frame field widths
  localparam int LEN_W  = 16;  // {LEN_HI, LEN_LO}
  localparam int WORD_W = 16;  // {W_HI, W_LO}

  // Frame parser states, named after the byte each state expects next
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_W_HI   = 3'd3,
    ST_W_LO   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_RUN    = 3'd6
  } state_t;

  // A frame fits when its word count does not exceed the RAM depth.
  // Evaluated at 17 bits so a 16-bit address space is still representable.
  function automatic logic len_fits(input logic [LEN_W-1:0] n, input int unsigned addr_w);
    logic [LEN_W:0] depth;
    depth = (LEN_W + 1)'(1) << addr_w;
    return ({1'b0, n} <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: prog_loader_if                                                  |
// | Purpose  : Bundles the loader's byte-stream input and its instruction RAM  |
// |            write port.                                                     |
// | Signals  : rx_data[7:0], rx_valid  byte stream into the loader             |
// |            rx_ready                 loader accepts the byte                |
// |            iWE, iAddr, iData        instruction RAM write port             |
// | Modports : slave  - the loader (consumes bytes, drives RAM writes)         |
// |            master - the environment (sources bytes, observes RAM writes)   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              iWE;
  logic [ADDR_W-1:0] iAddr;
  logic [15:0]       iData;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output iWE,
    output iAddr,
    output iData
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  iWE,
    input  iAddr,
    input  iData
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ld_timeout                                                       |
// | Purpose : Inter-byte idle watchdog. Down-counter reloaded by clr, counting |
// |           while en is high; expire pulses on the TIMEOUT-th idle cycle.    |
// | Ports   : clk, rst_n  clock, synchronous active-low reset                  |
// |           clr         reload (an accepted byte)                            |
// |           en          count enable (inside a frame)                        |
// |           expire      idle limit reached this cycle                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ld_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int              CNT_W = $clog2(TIMEOUT + 1);
  // Reload with TIMEOUT-1 so the zero count is reached on the TIMEOUT-th
  // enabled cycle after the reload edge.
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = LOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_loader                                                      |
// | Purpose : Boot-time writer for the instruction memory. Parses frames       |
// |           SYNC, LEN_HI, LEN_LO, N x (W_HI, W_LO), CSUM from a byte stream, |
// |           writes the words from address 0 and holds the CPU in reset until |
// |           a frame passes its checksum.                                     |
// | Ports   : clk, rst_n  clock, synchronous active-low reset                  |
// |           bus         prog_loader_if.slave: byte stream in, RAM writes out |
// |           cpu_rst     active-high processor reset                          |
// |           done        program loaded, CPU running                          |
// |           err         last frame failed (checksum, length or timeout)      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  state_t              state_q, state_d;
  logic [7:0]          sum_q, sum_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [7:0]          hi_q, hi_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                rx_ready_q, rx_ready_d;

  logic                acc;
  logic                tmo_en;
  logic                tmo_expire;
  logic [LEN_W-1:0]    len_n;
  logic [7:0]          sum_next;

  assign acc      = bus.rx_valid && rx_ready_q;
  assign len_n    = {len_hi_q, bus.rx_data};
  assign sum_next = sum_q + bus.rx_data;
  assign tmo_en   = (state_q != ST_IDLE) && (state_q != ST_RUN);

  ld_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    len_hi_d = len_hi_q;
    hi_d     = hi_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    data_d   = data_q;
    err_d    = err_q;

    // The address advances the cycle after its write strobe.
    if (we_q) begin
      addr_d = addr_q + 1'b1;
    end

    if (acc) begin
      // Every byte after SYNC, the checksum byte included, goes into the sum.
      sum_d = sum_next;
      case (state_q)
        ST_IDLE: begin
          sum_d = sum_q;
          if (bus.rx_data == SYNC) begin
            state_d = ST_LEN_HI;
            err_d   = 1'b0;
            addr_d  = '0;
            sum_d   = '0;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = bus.rx_data;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          if (!len_fits(len_n, ADDR_W)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (len_n == '0) begin
            state_d = ST_CSUM;
          end else begin
            rem_d   = len_n;
            state_d = ST_W_HI;
          end
        end
        ST_W_HI: begin
          hi_d    = bus.rx_data;
          state_d = ST_W_LO;
        end
        ST_W_LO: begin
          we_d    = 1'b1;
          data_d  = {hi_q, bus.rx_data};
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? ST_CSUM : ST_W_HI;
        end
        ST_CSUM: begin
          if (sum_next == 8'h00) begin
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (tmo_expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    // Registered so that ready is low throughout reset and rises one cycle
    // after it, and drops in the same cycle that RUN is entered.
    rx_ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sum_q      <= '0;
      len_hi_q   <= '0;
      hi_q       <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      len_hi_q   <= len_hi_d;
      hi_q       <= hi_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.iWE      = we_q;
  assign bus.iAddr    = addr_q;
  assign bus.iData    = data_q;
  assign cpu_rst      = (state_q != ST_RUN);
  assign done         = (state_q == ST_RUN);
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_prog_loader                                                   |
// | Purpose : Directed self-checking bench for prog_loader (ADDR_W=10,         |
// |           TIMEOUT=16).                                                     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst, done, err;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;
  int we_base;

  prog_loader_if #(.ADDR_W(10)) bus ();

  prog_loader #(
    .ADDR_W  (10),
    .SYNC    (8'hA5),
    .TIMEOUT (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Count write strobes, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.iWE) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns 1 time unit after the edge that accepted it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.rx_ready) begin
      chk("send_ready", {31'd0, bus.rx_ready}, 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_done"},    {31'd0, done},    32'd0);
    chk({tag, "_err"},     {31'd0, err},     32'd0);
    chk({tag, "_iWE"},     {31'd0, bus.iWE}, 32'd0);
    chk({tag, "_iAddr"},   {22'd0, bus.iAddr}, 32'd0);
    chk({tag, "_ready"},   {31'd0, bus.rx_ready}, 32'd0);
    rst_n = 1'b1;
    chk({tag, "_ready_rel"}, {31'd0, bus.rx_ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_ready_next"}, {31'd0, bus.rx_ready}, 32'd1);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #1;

    // 1: reset values and ready release
    do_reset("t1");

    // 2: good two-word frame
    we_base = we_cnt;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    chk("t2_we0",   {31'd0, bus.iWE}, 32'd1);
    chk("t2_addr0", {22'd0, bus.iAddr}, 32'd0);
    chk("t2_data0", {16'd0, bus.iData}, 32'h1234);
    send(8'hAB);
    chk("t2_we_pulse", {31'd0, bus.iWE}, 32'd0);
    chk("t2_addr_inc", {22'd0, bus.iAddr}, 32'd1);
    send(8'hCD);
    chk("t2_we1",   {31'd0, bus.iWE}, 32'd1);
    chk("t2_addr1", {22'd0, bus.iAddr}, 32'd1);
    chk("t2_data1", {16'd0, bus.iData}, 32'hABCD);
    chk("t2_run_early", {31'd0, done}, 32'd0);
    send(8'h40);
    chk("t2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("t2_done",    {31'd0, done},    32'd1);
    chk("t2_ready",   {31'd0, bus.rx_ready}, 32'd0);
    chk("t2_err",     {31'd0, err},     32'd0);
    chk("t2_wecnt",   we_cnt - we_base, 32'd2);
    repeat (3) @(posedge clk); #1;
    chk("t2_run_hold", {31'd0, done}, 32'd1);

    // 3: bad checksum, then good frame clears err
    do_reset("t3");
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'h41);
    chk("t3_err",     {31'd0, err},     32'd1);
    chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t3_done",    {31'd0, done},    32'd0);
    chk("t3_ready",   {31'd0, bus.rx_ready}, 32'd1);
    send(8'hA5);
    chk("t3_err_clr", {31'd0, err}, 32'd0);
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'h40);
    chk("t3_done2", {31'd0, done}, 32'd1);
    chk("t3_cpu_rst2", {31'd0, cpu_rst}, 32'd0);

    // 4: junk before an empty frame
    do_reset("t4");
    we_base = we_cnt;
    send(8'h00); send(8'hFF); send(8'h5A);
    chk("t4_idle_done", {31'd0, done}, 32'd0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("t4_done",  {31'd0, done}, 32'd1);
    chk("t4_wecnt", we_cnt - we_base, 32'd0);

    // 5: oversize length (1025 words)
    do_reset("t5");
    we_base = we_cnt;
    send(8'hA5); send(8'h04); send(8'h01);
    chk("t5_err",   {31'd0, err}, 32'd1);
    chk("t5_ready", {31'd0, bus.rx_ready}, 32'd1);
    send(8'h12); send(8'h34);
    chk("t5_wecnt", we_cnt - we_base, 32'd0);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("t5_recover", {31'd0, done}, 32'd1);

    // 6: inter-byte timeout of 16 cycles
    do_reset("t6");
    send(8'hA5); send(8'h00);
    repeat (15) @(posedge clk);
    #1;
    chk("t6_err_15", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("t6_err_16", {31'd0, err}, 32'd1);
    chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("t6_recover", {31'd0, done}, 32'd1);

    // 7: reset mid-frame, then a fresh frame starts at address 0
    do_reset("t7a");
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34); send(8'hAB);
    do_reset("t7b");
    send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    chk("t7_we0",   {31'd0, bus.iWE}, 32'd1);
    chk("t7_addr0", {22'd0, bus.iAddr}, 32'd0);
    chk("t7_data0", {16'd0, bus.iData}, 32'h1234);
    send(8'hAB); send(8'hCD);
    chk("t7_addr1", {22'd0, bus.iAddr}, 32'd1);
    send(8'h40);
    chk("t7_done", {31'd0, done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
